// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I datapath. It steps each instruction
// through fetch/decode/execute/memory/writeback and drives every datapath control.
module multicycle_control #(
   parameter bit HAS_MEM_READY = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       pc_source,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       instr_done,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXEC     = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8
   } state_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_source;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       instr_done;
      logic       illegal;
   } ctrl_t;

   state_t state_q;
   state_t state_d;
   ctrl_t  ctrl;
   logic   ready;
   logic   is_r;
   logic   is_load;
   logic   is_store;
   logic   is_beq;

   // Without a ready handshake the memory is assumed to answer in one cycle.
   assign ready = HAS_MEM_READY ? mem_ready : 1'b1;

   assign is_r     = (opcode == OP_R);
   assign is_load  = (opcode == OP_LOAD);
   assign is_store = (opcode == OP_STORE);
   assign is_beq   = (opcode == OP_BEQ);

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = S_FETCH;
      ctrl    = '0;
      ctrl.alu_src_b = SRCB_RS2;
      ctrl.alu_op    = ALUOP_ADD;

      case (state_q)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.ir_write  = ready;
            ctrl.pc_write  = ready;
            state_d        = ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            // Branch target is precomputed into ALUOut while the opcode is decoded.
            ctrl.alu_src_b = SRCB_IMM;
            if (is_load || is_store) state_d = S_MEMADR;
            else if (is_r)           state_d = S_EXEC;
            else if (is_beq)         state_d = S_BRANCH;
            else begin
               state_d      = S_FETCH;
               ctrl.illegal = 1'b1;
            end
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            state_d        = is_load ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
            state_d       = ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.instr_done = 1'b1;
            state_d         = S_FETCH;
         end
         S_MEMWRITE: begin
            ctrl.mem_write  = 1'b1;
            ctrl.i_or_d     = 1'b1;
            ctrl.instr_done = ready;
            state_d         = ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALUOP_FUNCT;
            state_d        = S_ALUWB;
         end
         S_ALUWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
            state_d         = S_FETCH;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = ALUOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = 1'b1;
            ctrl.instr_done    = 1'b1;
            state_d            = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
            ctrl    = '0;
         end
      endcase

      // Reset suppresses every enable at once, so an abandoned instruction never writes.
      if (rst) ctrl = '0;
   end

   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign pc_source     = ctrl.pc_source;
   assign i_or_d        = ctrl.i_or_d;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign ir_write      = ctrl.ir_write;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_write     = ctrl.reg_write;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ctrl.alu_op;
   assign instr_done    = ctrl.instr_done;
   assign illegal       = ctrl.illegal;
   assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-instruction expectations come from
// the phase/latency rules and are compared against counts gathered by a monitor.
module tb_multicycle_control;

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_L = 7'b0000011;
   localparam logic [6:0] OP_S = 7'b0100011;
   localparam logic [6:0] OP_B = 7'b1100011;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write;
   logic       ir_write, mem_to_reg, reg_write, alu_src_a, instr_done, illegal;
   logic [1:0] alu_src_b, alu_op;
   logic [3:0] state;

   logic [6:0] nr_opcode;
   logic       nr_pc_write, nr_pc_write_cond, nr_pc_source, nr_i_or_d, nr_mem_read, nr_mem_write;
   logic       nr_ir_write, nr_mem_to_reg, nr_reg_write, nr_alu_src_a, nr_instr_done, nr_illegal;
   logic [1:0] nr_alu_src_b, nr_alu_op;
   logic [3:0] nr_state;

   always #5 clk = ~clk;

   multicycle_control #(.HAS_MEM_READY(1'b1)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
      .illegal(illegal), .state(state)
   );

   multicycle_control #(.HAS_MEM_READY(1'b0)) dut_nr (
      .clk(clk), .rst(rst), .opcode(nr_opcode), .mem_ready(1'b0),
      .pc_write(nr_pc_write), .pc_write_cond(nr_pc_write_cond), .pc_source(nr_pc_source),
      .i_or_d(nr_i_or_d), .mem_read(nr_mem_read), .mem_write(nr_mem_write), .ir_write(nr_ir_write),
      .mem_to_reg(nr_mem_to_reg), .reg_write(nr_reg_write), .alu_src_a(nr_alu_src_a),
      .alu_src_b(nr_alu_src_b), .alu_op(nr_alu_op), .instr_done(nr_instr_done),
      .illegal(nr_illegal), .state(nr_state)
   );

   // Per-instruction summary: how many cycles each control was active, plus the state trace.
   typedef struct {
      int          cycles;
      int          ir;
      int          ir_at;
      int          pcw;
      int          mrd;
      int          mwr;
      int          iord;
      int          rw;
      int          m2r;
      int          op10;
      int          op01;
      int          pcwc;
      int          pcsrc;
      int          done;
      int          ill;
      logic [63:0] trace;
   } rec_t;

   rec_t sb[$];
   rec_t acc;
   bit   mon_en = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic bit is_legal(input logic [6:0] op);
      return op == OP_R || op == OP_L || op == OP_S || op == OP_B;
   endfunction

   function automatic rec_t empty_rec();
      rec_t r;
      r = '{cycles: 0, ir: 0, ir_at: -1, pcw: 0, mrd: 0, mwr: 0, iord: 0, rw: 0, m2r: 0,
            op10: 0, op01: 0, pcwc: 0, pcsrc: 0, done: 0, ill: 0, trace: '0};
      return r;
   endfunction

   task automatic compare_rec(input rec_t o, input rec_t e);
      check("cycles",     64'(o.cycles), 64'(e.cycles));
      check("trace",      o.trace,       e.trace);
      check("ir_write",   64'(o.ir),     64'(e.ir));
      check("ir_at",      64'(o.ir_at),  64'(e.ir_at));
      check("pc_write",   64'(o.pcw),    64'(e.pcw));
      check("mem_read",   64'(o.mrd),    64'(e.mrd));
      check("mem_write",  64'(o.mwr),    64'(e.mwr));
      check("i_or_d",     64'(o.iord),   64'(e.iord));
      check("reg_write",  64'(o.rw),     64'(e.rw));
      check("mem_to_reg", 64'(o.m2r),    64'(e.m2r));
      check("alu_op10",   64'(o.op10),   64'(e.op10));
      check("alu_op01",   64'(o.op01),   64'(e.op01));
      check("pc_wr_cond", 64'(o.pcwc),   64'(e.pcwc));
      check("pc_source",  64'(o.pcsrc),  64'(e.pcsrc));
      check("instr_done", 64'(o.done),   64'(e.done));
      check("illegal",    64'(o.ill),    64'(e.ill));
   endtask

   // Monitor: accumulate activity per cycle; an instruction ends on instr_done or illegal.
   always @(negedge clk) begin
      if (rst || !mon_en) begin
         acc = empty_rec();
      end else begin
         acc.trace = {acc.trace[59:0], state};
         if (ir_write) begin acc.ir++; acc.ir_at = acc.cycles; end
         acc.cycles++;
         acc.pcw   += int'(pc_write);
         acc.mrd   += int'(mem_read);
         acc.mwr   += int'(mem_write);
         acc.iord  += int'(i_or_d);
         acc.rw    += int'(reg_write);
         acc.m2r   += int'(mem_to_reg);
         acc.op10  += int'(alu_op == 2'b10);
         acc.op01  += int'(alu_op == 2'b01);
         acc.pcwc  += int'(pc_write_cond);
         acc.pcsrc += int'(pc_source);
         acc.done  += int'(instr_done);
         acc.ill   += int'(illegal);
         if (instr_done || illegal || acc.cycles > 20) begin
            if (sb.size() == 0) check("sb_underflow", 64'(1), 64'(0));
            else compare_rec(acc, sb.pop_front());
            acc = empty_rec();
         end
      end
   end

   // Build the expected phase list from the instruction class, queue the summary, then drive it.
   task automatic run_instr(input logic [6:0] op, input int wf, input int wm);
      rec_t       e;
      logic [3:0] st[$];
      bit         rdy[$];
      bit         use_op[$];
      bit         r_t, l_t, s_t, b_t, legal;
      r_t = (op == OP_R); l_t = (op == OP_L); s_t = (op == OP_S); b_t = (op == OP_B);
      legal = r_t || l_t || s_t || b_t;
      for (int i = 0; i <= wf; i++) begin st.push_back(4'd0); rdy.push_back(i == wf); use_op.push_back(1'b0); end
      st.push_back(4'd1); rdy.push_back(1'($urandom)); use_op.push_back(1'b1);
      if (r_t) begin
         st.push_back(4'd6); rdy.push_back(1'($urandom)); use_op.push_back(1'b0);
         st.push_back(4'd7); rdy.push_back(1'($urandom)); use_op.push_back(1'b0);
      end else if (l_t || s_t) begin
         st.push_back(4'd2); rdy.push_back(1'($urandom)); use_op.push_back(1'b1);
         for (int i = 0; i <= wm; i++) begin
            st.push_back(l_t ? 4'd3 : 4'd5); rdy.push_back(i == wm); use_op.push_back(1'b0);
         end
         if (l_t) begin st.push_back(4'd4); rdy.push_back(1'($urandom)); use_op.push_back(1'b0); end
      end else if (b_t) begin
         st.push_back(4'd8); rdy.push_back(1'($urandom)); use_op.push_back(1'b0);
      end
      e = empty_rec();
      foreach (st[i]) e.trace = {e.trace[59:0], st[i]};
      e.cycles = st.size();
      e.ir     = 1;
      e.ir_at  = wf;
      e.pcw    = 1;
      e.mrd    = wf + 1 + (l_t ? wm + 1 : 0);
      e.mwr    = s_t ? wm + 1 : 0;
      e.iord   = (l_t || s_t) ? wm + 1 : 0;
      e.rw     = (r_t || l_t) ? 1 : 0;
      e.m2r    = l_t ? 1 : 0;
      e.op10   = r_t ? 1 : 0;
      e.op01   = b_t ? 1 : 0;
      e.pcwc   = b_t ? 1 : 0;
      e.pcsrc  = b_t ? 1 : 0;
      e.done   = legal ? 1 : 0;
      e.ill    = legal ? 0 : 1;
      sb.push_back(e);
      foreach (st[i]) begin
         opcode    = use_op[i] ? op : 7'($urandom);
         mem_ready = rdy[i];
         @(posedge clk); #1;
      end
   endtask

   // Main stimulus.
   initial begin
      logic [6:0] op;
      int         k;
      rst = 1'b1; opcode = '0; mem_ready = 1'b0; nr_opcode = OP_L;
      @(posedge clk); #1;
      @(negedge clk);
      check("reset_state", 64'(state), 64'(0));
      check("reset_enables", 64'({pc_write, pc_write_cond, mem_read, mem_write, ir_write,
                                  reg_write, instr_done, illegal}), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0; mon_en = 1'b1;

      run_instr(OP_R, 0, 0);
      run_instr(OP_L, 2, 1);
      run_instr(OP_S, 0, 0);
      run_instr(OP_B, 0, 0);
      run_instr(7'b1111111, 0, 0);

      for (int n = 0; n < 40; n++) begin
         k = $urandom_range(0, 4);
         case (k)
            0: op = OP_R;
            1: op = OP_L;
            2: op = OP_S;
            3: op = OP_B;
            default: begin
               op = 7'($urandom);
               while (is_legal(op)) op = 7'($urandom);
            end
         endcase
         run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // Reset in the middle of a stalled store.
      mon_en = 1'b0;
      opcode = OP_S; mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("sw_stall_state", 64'(state), 64'(5));
      check("sw_stall_mem_write", 64'(mem_write), 64'(1));
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rst_mem_write", 64'(mem_write), 64'(0));
      check("rst_instr_done", 64'(instr_done), 64'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_state_after_edge", 64'(state), 64'(0));
      check("rst_no_enables", 64'({mem_read, mem_write, ir_write, pc_write, reg_write}), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0; mon_en = 1'b1;

      run_instr(OP_L, 1, 2);
      run_instr(OP_R, 0, 0);

      check("sb_drained", 64'(sb.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Single-cycle memory variant: lw runs 0,1,2,3,4 with mem_ready tied low.
   initial begin
      int nr_exp[6];
      nr_exp = '{0, 1, 2, 3, 4, 0};
      @(negedge clk);
      for (int i = 0; i < 50 && rst !== 1'b0; i++) @(negedge clk);
      check("nr_reset_release", 64'(rst), 64'(0));
      for (int c = 0; c < 6; c++) begin
         check($sformatf("nr_state%0d", c), 64'(nr_state), 64'(nr_exp[c]));
         check($sformatf("nr_done%0d", c), 64'(nr_instr_done), 64'(c == 4));
         @(negedge clk);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32I datapath; it is the producer of the 2-bit ALUOp code consumed by the ALU control decoder.
- Sequences fetch / decode / execute / memory / writeback for R-type, lw, sw and beq.
- Drives all datapath enables and mux selects.
- Stalls on a memory ready handshake.
- Flags unsupported opcodes.

Parameters:
- HAS_MEM_READY, 1: 1 = honour mem_ready; 0 = mem_ready internally treated as constant 1 (single-cycle memory).

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  instr[6:0] from the instruction register; valid from DECODE onward
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- pc_source  out  1  0 = ALU result, 1 = ALUOut register
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load instruction register
- mem_to_reg  out  1  register write data: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = rs1 register
- alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate
- alu_op  out  2  00 = add, 01 = subtract (beq), 10 = decode by funct fields
- instr_done  out  1  one-cycle pulse on the last cycle of each retired instruction
- illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode
- state  out  4  current state encoding (debug)

Behaviour:
- Opcodes:
  - R = 0110011
  - LOAD = 0000011
  - STORE = 0100011
  - BEQ = 1100011
  - anything else is illegal
- State encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXEC = 6, ALUWB = 7, BRANCH = 8.
- Codes 9–15 are unreachable. If ever entered, they behave as FETCH on the next edge (next state = FETCH, all enables 0).
- Output defaults in every state unless listed below: all 1-bit enables 0, pc_source 0, i_or_d 0, alu_src_a 0, alu_src_b 00, alu_op 00.
- FETCH:
  - Outputs: mem_read = 1, alu_src_b = 01.
  - ir_write = pc_write = mem_ready. This is Mealy-gated, so the PC and IR update only on the ready cycle.
  - Stay in FETCH while !mem_ready; otherwise go to DECODE.
- DECODE:
  - Outputs: alu_src_b = 10, computing the branch target into ALUOut.
  - LOAD or STORE → MEMADR; R → EXEC; BEQ → BRANCH.
  - Illegal opcode → FETCH with illegal = 1; instr_done stays 0.
- MEMADR:
  - Outputs: alu_src_a = 1, alu_src_b = 10.
  - LOAD → MEMREAD; otherwise → MEMWRITE.
- MEMREAD:
  - Outputs: mem_read = 1, i_or_d = 1.
  - Wait for mem_ready, then → MEMWB.
- MEMWB:
  - Outputs: reg_write = 1, mem_to_reg = 1, instr_done = 1.
  - Next → FETCH.
- MEMWRITE:
  - Outputs: mem_write = 1, i_or_d = 1.
  - instr_done = mem_ready.
  - Wait for mem_ready, then → FETCH.
- EXEC:
  - Outputs: alu_src_a = 1, alu_op = 10.
  - Next → ALUWB.
- ALUWB:
  - Outputs: reg_write = 1, instr_done = 1.
  - Next → FETCH.
- BRANCH:
  - Outputs: alu_src_a = 1, alu_op = 01, pc_write_cond = 1, pc_source = 1, instr_done = 1.
  - Next → FETCH.
- Memory handshake:
  - mem_read / mem_write are held constant for the whole wait.
  - mem_ready sampled outside FETCH, MEMREAD and MEMWRITE is ignored.
- Latency with mem_ready always 1 (total cycles per instruction):
  - R-type: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - illegal: 2
- Each wait cycle adds 1.
- Reset:
  - While rst = 1, all enables and pulses are 0 regardless of state.
  - The first edge with rst = 1 sets state = FETCH.
  - Reset mid-instruction (including during a memory wait) abandons the instruction without any write.
  - The first cycle after rst deasserts is FETCH.
- opcode is only used in DECODE and MEMADR; changes at other times have no effect.

Test Plan:
- Reset: hold rst for 2 cycles in MEMWRITE with mem_ready = 0 → mem_write = 0 during reset; state = 0 after the first edge; no write issued.
- R-type (opcode 0110011), mem_ready = 1:
  - state sequence 0, 1, 6, 7, 0
  - alu_op = 10 in EXEC
  - reg_write = 1 and instr_done = 1 only in ALUWB
  - 4 cycles total
- lw with 2 wait cycles in FETCH and 1 in MEMREAD:
  - states 0, 0, 0, 1, 2, 3, 3, 4
  - ir_write pulses exactly once, on the 3rd FETCH cycle
  - mem_to_reg = 1 in MEMWB
- sw then beq back-to-back:
  - sw: mem_write = 1, i_or_d = 1 in state 5
  - beq: state 8 shows alu_op = 01, pc_write_cond = 1, pc_source = 1
  - instr_done pulses twice in total
- Illegal opcode 1111111: state 1 → 0, illegal = 1 for exactly 1 cycle, no reg_write/mem_write/instr_done.
- HAS_MEM_READY = 0 with mem_ready tied 0: lw completes in 5 cycles with no stall.
